// File: rtl/mem_bist_initiator.sv
// Memory self-test initiator on the picorv32 native bus: four write/read passes over NWORDS words,
// counting read mismatches and aborting a request that waits TIMEOUT cycles for mem_ready.
module mem_bist_initiator #(
    parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
    parameter int unsigned NWORDS    = 128,
    parameter logic [31:0] SEED      = 32'h1234_5678,
    parameter int unsigned TIMEOUT   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [15:0] err_count,
    output logic [31:0] first_err_addr,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_wstrb,
    input  logic [31:0] mem_rdata
);
    // Handshake: a request is held stable while mem_valid=1 and completes on the first rising edge
    // with mem_valid=1 and mem_ready=1; mem_valid then drops for at least one cycle (GAP), and the
    // next request only starts once mem_ready has been seen low, so a lingering ready never counts.
    localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [31:0]   BASE     = {ADDR_BASE[31:2], 2'b00};
    localparam logic [IW-1:0] LAST_IDX = IW'(NWORDS - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, REQ, GAP, DONE} state_t;

    state_t        state, state_nxt;
    logic [1:0]    phase;
    logic [IW-1:0] idx;
    logic [TW-1:0] tcnt;
    logic [15:0]   idx16;
    logic [31:0]   pat, lane_mask, exp_data;
    logic          accept, tmo_hit, last_word, is_read, mismatch;

    assign idx16     = 16'(idx);
    assign pat       = SEED ^ {~idx16, idx16};
    assign lane_mask = 32'h0000_00FF << {idx16[1:0], 3'b000};
    assign exp_data  = phase[1] ? (pat ^ lane_mask) : pat;
    assign is_read   = phase[0];
    assign mismatch  = is_read && (mem_rdata != exp_data);
    assign accept    = start && ((state == IDLE) || (state == DONE));
    assign tmo_hit   = (state == REQ) && !mem_ready && (tcnt == TMO_LAST);
    assign last_word = (idx == LAST_IDX) && (phase == 2'd3);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = REQ;
            REQ: begin
                if (mem_ready)    state_nxt = last_word ? DONE : GAP;
                else if (tmo_hit) state_nxt = DONE;
            end
            GAP:     if (!mem_ready) state_nxt = REQ;
            DONE:    if (start) state_nxt = REQ;
            default: state_nxt = IDLE;
        endcase
    end

    // Bus outputs are forced to zero outside REQ so reset and idle present a quiet bus.
    always_comb begin
        mem_valid = (state == REQ);
        busy      = (state == REQ) || (state == GAP);
        done      = (state == DONE);
        pass      = (state == DONE) && (err_count == 16'h0000) && !timeout;
        mem_addr  = 32'h0000_0000;
        mem_wdata = 32'h0000_0000;
        mem_wstrb = 4'b0000;
        if (state == REQ) begin
            mem_addr = BASE + 32'({idx16, 2'b00});
            case (phase)
                2'd0: begin
                    mem_wstrb = 4'b1111;
                    mem_wdata = pat;
                end
                2'd2: begin
                    mem_wstrb = 4'b0001 << idx16[1:0];
                    mem_wdata = ~pat;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase          <= 2'd0;
            idx            <= '0;
            tcnt           <= '0;
            err_count      <= 16'h0000;
            first_err_addr <= 32'h0000_0000;
            timeout        <= 1'b0;
        end else if (accept) begin
            phase          <= 2'd0;
            idx            <= '0;
            tcnt           <= '0;
            err_count      <= 16'h0000;
            first_err_addr <= 32'h0000_0000;
            timeout        <= 1'b0;
        end else if (state == REQ) begin
            if (mem_ready) begin
                tcnt <= '0;
                if (mismatch) begin
                    if (err_count == 16'h0000) first_err_addr <= mem_addr;
                    if (err_count != 16'hFFFF) err_count <= err_count + 16'h0001;
                end
                if (idx == LAST_IDX) begin
                    idx   <= '0;
                    phase <= phase + 2'd1;
                end else begin
                    idx <= idx + IW'(1);
                end
            end else if (tmo_hit) begin
                tcnt    <= '0;
                timeout <= 1'b1;
            end else begin
                tcnt <= tcnt + TW'(1);
            end
        end else begin
            tcnt <= '0;
        end
    end
endmodule

// File: tb/tb_mem_bist_initiator.sv
// Directed bench for mem_bist_initiator: a 128-word responder model with selectable ready
// behaviour and an injectable stuck-at-1 bit, checked against hand-derived transaction sequences.
module tb_mem_bist_initiator;
    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, pass, timeout;
    logic [15:0] err_count;
    logic [31:0] first_err_addr;
    logic        mem_valid, mem_ready;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_wstrb;

    // 0: registered ready pulse, 1: never ready, 2: ready follows valid (sticky), 3: combinational
    int          resp_mode;
    logic        ready_q;
    logic        fault_en;
    logic [6:0]  fault_word;
    int          fault_bit;
    logic [31:0] mem [0:127];
    logic [31:0] cur_word, wr_merged;
    logic        prev_valid;
    int          stale_cnt;

    logic [31:0] log_addr[$];
    logic [3:0]  log_wstrb[$];
    logic [31:0] log_wdata[$];
    logic [31:0] log_rdata[$];

    int n_vec = 0;
    int n_miss = 0;

    mem_bist_initiator #(
        .ADDR_BASE(32'h0000_0000), .NWORDS(128), .SEED(32'h1234_5678), .TIMEOUT(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .pass(pass),
        .timeout(timeout), .err_count(err_count), .first_err_addr(first_err_addr),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // ---------------- responder model ----------------
    assign mem_ready = (resp_mode == 3) ? mem_valid : ready_q;
    assign cur_word  = mem[mem_addr[8:2]];
    assign mem_rdata = cur_word | ((fault_en && (mem_addr[8:2] == fault_word)) ? (32'h1 << fault_bit) : 32'h0);
    assign wr_merged = {mem_wstrb[3] ? mem_wdata[31:24] : cur_word[31:24],
                        mem_wstrb[2] ? mem_wdata[23:16] : cur_word[23:16],
                        mem_wstrb[1] ? mem_wdata[15:8]  : cur_word[15:8],
                        mem_wstrb[0] ? mem_wdata[7:0]   : cur_word[7:0]};

    always @(posedge clk or posedge rst) begin
        if (rst) ready_q <= 1'b0;
        else begin
            case (resp_mode)
                0:       ready_q <= mem_valid && !ready_q;
                2:       ready_q <= mem_valid;
                default: ready_q <= 1'b0;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!rst && mem_valid && mem_ready && (mem_wstrb != 4'b0000))
            mem[mem_addr[8:2]] <= wr_merged;
    end

    // Transaction monitor, sampled mid-cycle.
    always @(negedge clk) begin
        if (!rst && mem_valid && mem_ready) begin
            log_addr.push_back(mem_addr);
            log_wstrb.push_back(mem_wstrb);
            log_wdata.push_back(mem_wdata);
            log_rdata.push_back(mem_rdata);
            if (resp_mode == 2 && !prev_valid) stale_cnt <= stale_cnt + 1;
        end
        prev_valid <= mem_valid;
    end

    // ---------------- driver tasks ----------------
    task automatic clear_log();
        log_addr.delete();
        log_wstrb.delete();
        log_wdata.delete();
        log_rdata.delete();
    endtask

    task automatic start_pulse();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit ok = 1'b0;
        for (int c = 0; c < 6000; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL %s_done_wait: done never rose within 6000 cycles", name);
        end
    endtask

    task automatic run_once(input string name);
        clear_log();
        start_pulse();
        wait_done(name);
    endtask

    function automatic logic [67:0] exp_txn(input int t);
        int          ph, i;
        logic [15:0] i16;
        logic [31:0] p, m, a;
        ph  = t / 128;
        i   = t % 128;
        i16 = 16'(i);
        p   = 32'h1234_5678 ^ {~i16, i16};
        m   = 32'h0000_00FF << (8 * (i % 4));
        a   = 32'(4 * i);
        case (ph)
            0:       return {a, 4'b1111, p};
            1:       return {a, 4'b0000, p};
            2:       return {a, 4'(1 << (i % 4)), ~p};
            default: return {a, 4'b0000, p ^ m};
        endcase
    endfunction

    // Writes are compared on wdata, reads on the data the responder returned.
    task automatic check_sequence(input string name);
        logic [67:0] got, want;
        n_vec++;
        if (log_addr.size() != 512) begin
            n_miss++;
            $display("FAIL %s_count: got %0d transactions, want 512", name, log_addr.size());
        end else begin
            for (int t = 0; t < 512; t++) begin
                want = exp_txn(t);
                got  = {log_addr[t], log_wstrb[t], (log_wstrb[t] != 4'b0000) ? log_wdata[t] : log_rdata[t]};
                n_vec++;
                if (got !== want) begin
                    n_miss++;
                    $display("FAIL %s_txn%0d: got addr/strb/data %h, want %h", name, t, got, want);
                end
            end
        end
    endtask

    task automatic check_result(input string name, input logic exp_pass, input logic exp_tmo,
                                input logic [15:0] exp_err, input logic [31:0] exp_first);
        n_vec++;
        if ({done, busy, pass, timeout} !== {1'b1, 1'b0, exp_pass, exp_tmo}) begin
            n_miss++;
            $display("FAIL %s_flags: got done/busy/pass/timeout %b, want %b", name,
                     {done, busy, pass, timeout}, {1'b1, 1'b0, exp_pass, exp_tmo});
        end
        n_vec++;
        if (err_count !== exp_err) begin
            n_miss++;
            $display("FAIL %s_err_count: got %0d, want %0d", name, err_count, exp_err);
        end
        n_vec++;
        if (first_err_addr !== exp_first) begin
            n_miss++;
            $display("FAIL %s_first_err_addr: got %h, want %h", name, first_err_addr, exp_first);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b1;
        repeat (3) @(negedge clk);
        n_vec++;
        if ({busy, done, pass, timeout, mem_valid, mem_wstrb} !== 9'b0) begin
            n_miss++;
            $display("FAIL reset_ctrl: got %b, want 000000000", {busy, done, pass, timeout, mem_valid, mem_wstrb});
        end
        n_vec++;
        if ({err_count, first_err_addr, mem_addr, mem_wdata} !== 112'b0) begin
            n_miss++;
            $display("FAIL reset_data: got err %h first %h addr %h wdata %h, want all 0",
                     err_count, first_err_addr, mem_addr, mem_wdata);
        end
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_vec++;
        if ({busy, mem_valid} !== 2'b00) begin
            n_miss++;
            $display("FAIL reset_start_ignored: got busy/valid %b, want 00", {busy, mem_valid});
        end
    endtask

    task automatic test_good_run();
        resp_mode = 0;
        run_once("good");
        check_result("good", 1'b1, 1'b0, 16'd0, 32'h0);
        check_sequence("good");
        if (log_addr.size() == 512) begin
            n_vec++;
            if ({log_wstrb[257], log_wdata[257]} !== {4'b0010, 32'h1235_A986}) begin
                n_miss++;
                $display("FAIL good_p2_w1: got %b %h, want 0010 1235a986", log_wstrb[257], log_wdata[257]);
            end
            n_vec++;
            if (log_rdata[385] !== 32'hEDCA_A979) begin
                n_miss++;
                $display("FAIL good_p3_w1: got %h, want edcaa979", log_rdata[385]);
            end
            n_vec++;
            if (log_rdata[128] !== 32'hEDCB_5678) begin
                n_miss++;
                $display("FAIL good_p1_w0: got %h, want edcb5678", log_rdata[128]);
            end
        end
    endtask

    // Bit 0 of word 0: phase 1 expects ..78 (mismatch), phase 3 expects ..87 (bit 0 already 1).
    task automatic test_stuck_bit0();
        resp_mode = 0;
        fault_en = 1'b1; fault_word = 7'd0; fault_bit = 0;
        run_once("stuck_b0");
        fault_en = 1'b0;
        check_result("stuck_b0", 1'b0, 1'b0, 16'd1, 32'h0000_0000);
    endtask

    // Bit 8 of word 2 sits in an untouched lane and is 0 in both expected values: two mismatches.
    task automatic test_stuck_lane1();
        resp_mode = 0;
        fault_en = 1'b1; fault_word = 7'd2; fault_bit = 8;
        run_once("stuck_w2b8");
        fault_en = 1'b0;
        check_result("stuck_w2b8", 1'b0, 1'b0, 16'd2, 32'h0000_0008);
    endtask

    task automatic test_timeout();
        int  cnt = 0;
        bit  ok = 1'b0;
        resp_mode = 1;
        clear_log();
        start_pulse();
        for (int c = 0; c < 100; c++) begin
            if (done) begin
                ok = 1'b1;
                break;
            end
            if (mem_valid) cnt++;
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL timeout_done_wait: done never rose within 100 cycles");
        end
        n_vec++;
        if (cnt !== 16) begin
            n_miss++;
            $display("FAIL timeout_valid_cycles: got %0d, want 16", cnt);
        end
        check_result("timeout", 1'b0, 1'b1, 16'd0, 32'h0);
        n_vec++;
        if ({mem_valid, 32'(log_addr.size())} !== {1'b0, 32'd0}) begin
            n_miss++;
            $display("FAIL timeout_no_txn: got valid %b txns %0d, want 0 0", mem_valid, log_addr.size());
        end
    endtask

    task automatic test_sticky_ready();
        resp_mode = 2;
        stale_cnt = 0;
        clear_log();
        start_pulse();
        n_vec++;
        if ({done, busy, timeout} !== 3'b010) begin
            n_miss++;
            $display("FAIL sticky_start_clear: got done/busy/timeout %b, want 010", {done, busy, timeout});
        end
        wait_done("sticky");
        check_result("sticky", 1'b1, 1'b0, 16'd0, 32'h0);
        check_sequence("sticky");
        n_vec++;
        if (stale_cnt !== 0) begin
            n_miss++;
            $display("FAIL sticky_stale_complete: got %0d, want 0", stale_cnt);
        end
    endtask

    task automatic test_comb_ready();
        resp_mode = 3;
        run_once("comb");
        check_result("comb", 1'b1, 1'b0, 16'd0, 32'h0);
        check_sequence("comb");
    endtask

    task automatic test_reset_mid_run();
        bit ok = 1'b0;
        resp_mode = 0;
        clear_log();
        start_pulse();
        for (int c = 0; c < 2000; c++) begin
            if (log_addr.size() >= 140 && mem_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        n_vec++;
        if (!ok) begin
            n_miss++;
            $display("FAIL midrst_reach_phase1: never reached phase 1 with valid high");
        end
        rst = 1'b1;
        #1;
        n_vec++;
        if ({mem_valid, busy, done} !== 3'b000) begin
            n_miss++;
            $display("FAIL midrst_immediate: got valid/busy/done %b, want 000", {mem_valid, busy, done});
        end
        @(negedge clk);
        rst = 1'b0;
        run_once("midrst_rerun");
        check_result("midrst_rerun", 1'b1, 1'b0, 16'd0, 32'h0);
        check_sequence("midrst_rerun");
    endtask

    task automatic test_start_while_busy();
        resp_mode = 0;
        clear_log();
        start_pulse();
        repeat (100) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            start = 1'b1;
            @(negedge clk);
            start = 1'b0;
            repeat (7) @(negedge clk);
        end
        wait_done("busy_start");
        check_result("busy_start", 1'b1, 1'b0, 16'd0, 32'h0);
        check_sequence("busy_start");
    endtask

    task automatic test_restart_from_done();
        resp_mode = 0;
        fault_en = 1'b1; fault_word = 7'd2; fault_bit = 8;
        run_once("restart_fault");
        fault_en = 1'b0;
        check_result("restart_fault", 1'b0, 1'b0, 16'd2, 32'h0000_0008);
        clear_log();
        start_pulse();
        n_vec++;
        if ({done, busy, pass, err_count, first_err_addr} !== {3'b010, 48'h0}) begin
            n_miss++;
            $display("FAIL restart_cleared: got done/busy/pass %b err %0d first %h, want 010 0 0",
                     {done, busy, pass}, err_count, first_err_addr);
        end
        wait_done("restart");
        check_result("restart", 1'b1, 1'b0, 16'd0, 32'h0);
        check_sequence("restart");
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        resp_mode = 0;
        fault_en = 1'b0;
        fault_word = 7'd0;
        fault_bit = 0;
        stale_cnt = 0;
        prev_valid = 1'b0;
        for (int w = 0; w < 128; w++) mem[w] = 32'h0;
        test_reset();
        test_good_run();
        test_stuck_bit0();
        test_stuck_lane1();
        test_timeout();
        test_sticky_ready();
        test_comb_ready();
        test_reset_mid_run();
        test_start_while_busy();
        test_restart_from_done();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
